// File: rtl/mult_iter_unit.sv
//------------------------------------------------------------------------------
// mult_iter_unit
//
// Multi-cycle iterative multiplier for one execute issue slot. A request on
// multsele (taken only while idle) latches the operand magnitudes. A shift-add
// loop then retires BPC multiplier bits per cycle. The sign is restored
// afterwards and the 2*WIDTH-bit product is presented with a one-cycle
// multready pulse.
//
// Ports
//   clk        : clock, rising edge
//   resetn     : asynchronous reset, active low
//   signe      : 1 = signed (two's complement) multiply, 0 = unsigned
//   multsele   : multiply request from execute, sampled only in IDLE
//   multabort  : flush of the requesting instruction; cancels in-flight work
//   srcae      : multiplicand, sampled only at start
//   srcbe      : multiplier, sampled only at start
//   product    : registered 2*WIDTH-bit result, held until next completion
//   multready  : one-cycle pulse when product is valid
//   multbusy   : high while the loop or sign fix-up is running (stall source)
//
// Parameters
//   WIDTH      : operand width
//   BPC        : multiplier bits retired per BUSY cycle (1, 2 or 4, divides WIDTH)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mult_iter_unit #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 signe,
   input  logic                 multsele,
   input  logic                 multabort,
   input  logic [WIDTH-1:0]     srcae,
   input  logic [WIDTH-1:0]     srcbe,
   output logic [2*WIDTH-1:0]   product,
   output logic                 multready,
   output logic                 multbusy
);

   localparam int K  = WIDTH / BPC;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state;
   logic [2*WIDTH-1:0]    acc;
   logic [2*WIDTH-1:0]    mcand;     // multiplicand, pre-shifted to the current bit weight
   logic [WIDTH-1:0]      mplier;    // multiplier, consumed from the LSB end
   logic                  neg;
   logic [CW-1:0]         cnt;
   logic [2*WIDTH-1:0]    pp;

   // Magnitude of a WIDTH-bit operand. The most negative value maps onto
   // 2^(WIDTH-1), which still fits because the result is treated as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             s);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      return (s && v[WIDTH-1]) ? WIDTH'(-sv) : v;
   endfunction

   // Restore the product sign in 2*WIDTH-bit two's complement.
   function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] a,
                                                   input logic               n);
      logic signed [2*WIDTH-1:0] sa;
      sa = a;
      return n ? (2*WIDTH)'(-sa) : a;
   endfunction

   // Partial product for the BPC multiplier bits retired this cycle.
   always_comb begin
      pp = '0;
      for (int i = 0; i < BPC; i++) begin
         if (mplier[i]) begin
            pp = pp + (mcand << i);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         neg       <= 1'b0;
         cnt       <= '0;
         product   <= '0;
         multready <= 1'b0;
         multbusy  <= 1'b0;
      end else begin
         multready <= 1'b0;
         case (state)
            IDLE: begin
               // Abort wins over a simultaneous request.
               if (multsele && !multabort) begin
                  mcand    <= {{WIDTH{1'b0}}, magnitude(srcae, signe)};
                  mplier   <= magnitude(srcbe, signe);
                  neg      <= signe & (srcae[WIDTH-1] ^ srcbe[WIDTH-1]);
                  acc      <= '0;
                  cnt      <= '0;
                  multbusy <= 1'b1;
                  state    <= BUSY;
               end
            end

            BUSY: begin
               if (multabort) begin
                  multbusy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  acc    <= acc + pp;
                  mcand  <= mcand << BPC;
                  mplier <= mplier >> BPC;
                  cnt    <= cnt + CW'(1);
                  if (cnt == CW'(K - 1)) begin
                     state <= SIGN;
                  end
               end
            end

            SIGN: begin
               multbusy <= 1'b0;
               if (multabort) begin
                  state <= IDLE;
               end else begin
                  product   <= sign_fix(acc, neg);
                  multready <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               // Request is deliberately not sampled here so the still-stalled
               // instruction cannot start a second multiply.
               state <= IDLE;
            end

            default: begin
               multbusy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
